regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter BUF_DEPTH, default 2, giving the number of entries in the long-latency result buffer (legal values are 2 or 4).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  the single clock.
- rst  in  1  synchronous, active-high reset.
- stallW  in  1  writeback stage stalled.
- p_we  in  1  pipeline writeback request.
- p_wa  in  5  pipeline writeback address.
- p_wd  in  32  pipeline writeback data.
- m_issue  in  1  a multi-cycle op (div/mul/miss-load) issues this cycle.
- m_issue_wa  in  5  destination of the issuing op.
- m_valid  in  1  multi-cycle result valid.
- m_wa  in  5  result address.
- m_wd  in  32  result data.
- m_ready  out  1  result accepted when high together with m_valid.
- ra1, ra2  in  5  decode source addresses.
- dst  in  5  decode destination address.
- hazard  out  1  decode must stall.
- fwd1_v, fwd2_v  out  1  forwarded operand valid.
- fwd1_d, fwd2_d  out  32  forwarded operand data.
- issue_err  out  1  sticky protocol error.
- we3  out  1  regfile write enable.
- wa3  out  5  regfile write address.
- wd3  out  32  regfile write data.

Function
REQ-003 The block SHALL grant the write port to the pipeline when p_we & ~stallW & (p_wa != 0), driving we3=1, wa3=p_wa and wd3=p_wd combinationally in that cycle.
REQ-004 When the pipeline is not granted and the buffer is non-empty, the block SHALL drain the buffer head to we3/wa3/wd3 and pop it at the clock edge.
REQ-005 The block SHALL drive we3=0 when there is neither a pipeline grant nor a drain; the pipeline always has priority over the buffer.
REQ-006 The block SHALL drive m_ready = ~full, where full is computed from the registered count before the current cycle's pop.
REQ-007 On m_valid & m_ready with m_wa != 0, the block SHALL push {m_wa, m_wd} into the buffer; the earliest write of that result is the following cycle.
REQ-008 On m_valid & m_ready with m_wa == 0, the block SHALL accept the result and discard it without pushing.
REQ-009 A push and a pop in the same cycle SHALL leave the count unchanged; the pointers SHALL wrap modulo BUF_DEPTH.
REQ-010 The block SHALL keep a 32-bit pending vector with bit 0 hard-wired to 0.
REQ-011 On m_issue with m_issue_wa != 0 and that bit clear, the block SHALL set the bit at the edge.
REQ-012 When a drain writes address A, the block SHALL clear pending[A] at the edge.
REQ-013 If the same bit is set by an issue and cleared by a drain in the same cycle, the set SHALL win.
REQ-014 On m_issue to a register whose pending bit is already set, the block SHALL leave the pending vector unchanged and set issue_err, which holds until reset.
REQ-015 The block SHALL drive hazard = pending[ra1] | pending[ra2] | pending[dst], combinationally; dst covers the WAW case.
REQ-016 hazard SHALL NOT depend on m_issue or m_valid, so that no combinational loop is formed through the issue logic.

Reset
REQ-017 While rst is high at a clock edge, the block SHALL empty the buffer (pointers and count to 0), clear the pending vector and clear issue_err.
REQ-018 During a reset cycle, the block SHALL force m_ready=0, we3=0, hazard=0, fwd1_v=0 and fwd2_v=0.
REQ-019 A reset asserted mid-drain SHALL discard all buffered results; no write SHALL be issued in the reset cycle.

Configuration
REQ-020 With macro REGFILE_WB_FWD_EN defined, for each read port n the block SHALL search the buffer for the youngest valid entry with address equal to ran (ran != 0).
REQ-021 With REGFILE_WB_FWD_EN defined and such an entry found, the block SHALL drive fwdn_v=1 and fwdn_d=entry data, and remove that operand's term from hazard; the dst term is unaffected.
REQ-022 With REGFILE_WB_FWD_EN undefined, the block SHALL tie fwd1_v, fwd2_v, fwd1_d and fwd2_d to 0, SHALL contain no compare logic, and hazard SHALL follow REQ-015 exactly.

Verification
REQ-023 The bench SHALL cover: p_we=1, p_wa=5, p_wd=0x11, stallW=0 with buffer empty -> we3=1, wa3=5, wd3=0x11 in the same cycle.
REQ-024 The bench SHALL cover: m_issue to r8, then m_valid r8=0xAB with p_we=1 every cycle for 3 cycles -> m_ready=1 at accept; r8 is not written while p_we is held; hazard stays 1 for ra1=8 until the cycle after p_we drops, then wa3=8, wd3=0xAB and hazard=0 on the next cycle.
REQ-025 The bench SHALL cover: BUF_DEPTH=2, two results accepted while p_we is held -> m_ready=0 on the following cycle; a third m_valid is held off; after p_we drops, drain order is first result then second.
REQ-026 The bench SHALL cover: m_issue r3 twice without any drain -> issue_err=1 and pending[3] still 1; the first drain of r3 clears hazard.
REQ-027 The bench SHALL cover: m_valid with m_wa=0 and m_wd=0xFFFF -> accepted, we3 never asserts, buffer count stays 0.
REQ-028 The bench SHALL cover: REGFILE_WB_FWD_EN defined, r9=0x55 buffered and the port blocked, ra2=9 -> fwd2_v=1, fwd2_d=0x55, hazard=0 with ra1=0 and dst=0; then rst mid-drain -> buffer empty and we3=0 in the reset cycle.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter_if
//  Purpose  : Bundle of the writeback-arbiter signals: pipeline writeback,
//             multi-cycle result return, decode hazard/forwarding and
//             register-file write port.
//  Revision : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if;
    logic        stallW;
    logic        p_we;
    logic [4:0]  p_wa;
    logic [31:0] p_wd;
    logic        m_issue;
    logic [4:0]  m_issue_wa;
    logic        m_valid;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic        m_ready;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  dst;
    logic        hazard;
    logic        fwd1_v;
    logic        fwd2_v;
    logic [31:0] fwd1_d;
    logic [31:0] fwd2_d;
    logic        issue_err;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;

    modport master (
        output stallW, p_we, p_wa, p_wd,
        output m_issue, m_issue_wa, m_valid, m_wa, m_wd,
        output ra1, ra2, dst,
        input  m_ready, hazard, fwd1_v, fwd2_v, fwd1_d, fwd2_d,
        input  issue_err, we3, wa3, wd3
    );

    modport slave (
        input  stallW, p_we, p_wa, p_wd,
        input  m_issue, m_issue_wa, m_valid, m_wa, m_wd,
        input  ra1, ra2, dst,
        output m_ready, hazard, fwd1_v, fwd2_v, fwd1_d, fwd2_d,
        output issue_err, we3, wa3, wd3
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Shares the register-file write port between the pipeline and a
//             small FIFO of long-latency results; tracks pending destinations
//             for decode hazards. Optional buffer forwarding: REGFILE_WB_FWD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int BUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int                   c_PTR_W    = $clog2(BUF_DEPTH);
    localparam int                   c_CNT_W    = c_PTR_W + 1;
    localparam logic [c_PTR_W-1:0]   c_LAST_PTR = c_PTR_W'(BUF_DEPTH - 1);
    localparam logic [c_CNT_W-1:0]   c_FULL_CNT = c_CNT_W'(BUF_DEPTH);

    logic [4:0]          r_buf_wa [BUF_DEPTH];
    logic [31:0]         r_buf_wd [BUF_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [31:1]         r_pending;
    logic                r_issue_err;

    logic                w_full;
    logic                w_empty;
    logic                w_pipe_grant;
    logic                w_drain;
    logic                w_m_ready;
    logic                w_accept;
    logic                w_push;
    logic                w_issue;
    logic                w_issue_dup;
    logic [31:0]         w_pending;
    logic [31:1]         w_pending_nxt;
    logic [4:0]          w_head_wa;
    logic [31:0]         w_head_wd;
    logic                w_fwd1_hit;
    logic                w_fwd2_hit;
    logic [31:0]         w_fwd1_data;
    logic [31:0]         w_fwd2_data;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Write-port arbitration: pipeline first, buffer head otherwise
    // ------------------------------------------------------------------
    assign w_full       = (r_count == c_FULL_CNT);
    assign w_empty      = (r_count == '0);
    assign w_head_wa    = r_buf_wa[r_rd_ptr];
    assign w_head_wd    = r_buf_wd[r_rd_ptr];
    assign w_pipe_grant = ~rst & bus.p_we & ~bus.stallW & (bus.p_wa != 5'd0);
    assign w_drain      = ~rst & ~w_pipe_grant & ~w_empty;

    assign bus.we3 = w_pipe_grant | w_drain;
    assign bus.wa3 = w_pipe_grant ? bus.p_wa : (w_drain ? w_head_wa : 5'd0);
    assign bus.wd3 = w_pipe_grant ? bus.p_wd : (w_drain ? w_head_wd : 32'd0);

    // Ready uses the count before this cycle's pop, so a full buffer
    // refuses a result even while it is draining.
    assign w_m_ready   = ~rst & ~w_full;
    assign bus.m_ready = w_m_ready;
    assign w_accept    = bus.m_valid & w_m_ready;
    assign w_push      = w_accept & (bus.m_wa != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_drain) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_drain})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_wa[r_wr_ptr] <= bus.m_wa;
            r_buf_wd[r_wr_ptr] <= bus.m_wd;
        end
    end

    // ------------------------------------------------------------------
    // Pending-destination scoreboard; an issue set beats a drain clear
    // ------------------------------------------------------------------
    assign w_pending   = {r_pending, 1'b0};
    assign w_issue     = bus.m_issue & (bus.m_issue_wa != 5'd0);
    assign w_issue_dup = w_issue & w_pending[bus.m_issue_wa];

    always_comb begin
        w_pending_nxt = r_pending;
        for (int b = 1; b < 32; b++) begin
            if (w_drain && (w_head_wa == 5'(b))) begin
                w_pending_nxt[b] = 1'b0;
            end
            if (w_issue && (bus.m_issue_wa == 5'(b))) begin
                w_pending_nxt[b] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= '0;
            r_issue_err <= 1'b0;
        end else begin
            r_pending   <= w_pending_nxt;
            r_issue_err <= r_issue_err | w_issue_dup;
        end
    end

    assign bus.issue_err = r_issue_err;

    // ------------------------------------------------------------------
    // Forwarding from the result buffer
    // ------------------------------------------------------------------
`ifdef REGFILE_WB_FWD_EN
    logic [c_PTR_W-1:0] w_fwd_idx;

    // Walk oldest to youngest so the youngest match is the one kept.
    always_comb begin
        w_fwd1_hit  = 1'b0;
        w_fwd2_hit  = 1'b0;
        w_fwd1_data = 32'd0;
        w_fwd2_data = 32'd0;
        w_fwd_idx   = r_rd_ptr;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            w_fwd_idx = c_PTR_W'(int'(r_rd_ptr) + i);
            if (i < int'(r_count)) begin
                if ((bus.ra1 != 5'd0) && (r_buf_wa[w_fwd_idx] == bus.ra1)) begin
                    w_fwd1_hit  = 1'b1;
                    w_fwd1_data = r_buf_wd[w_fwd_idx];
                end
                if ((bus.ra2 != 5'd0) && (r_buf_wa[w_fwd_idx] == bus.ra2)) begin
                    w_fwd2_hit  = 1'b1;
                    w_fwd2_data = r_buf_wd[w_fwd_idx];
                end
            end
        end
    end
`else
    assign w_fwd1_hit  = 1'b0;
    assign w_fwd2_hit  = 1'b0;
    assign w_fwd1_data = 32'd0;
    assign w_fwd2_data = 32'd0;
`endif

    assign bus.fwd1_v = ~rst & w_fwd1_hit;
    assign bus.fwd2_v = ~rst & w_fwd2_hit;
    assign bus.fwd1_d = w_fwd1_data;
    assign bus.fwd2_d = w_fwd2_data;

    // Only registered state feeds the hazard, keeping it free of the
    // issue/valid inputs; the dst term is never hidden by forwarding.
    assign bus.hazard = ~rst & ((w_pending[bus.ra1] & ~w_fwd1_hit) |
                                (w_pending[bus.ra2] & ~w_fwd2_hit) |
                                 w_pending[bus.dst]);

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Directed scenarios plus random traffic against a queue-based
//             reference model of the writeback arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int BUF_DEPTH = 2;
`ifdef REGFILE_WB_FWD_EN
    localparam bit c_FWD = 1'b1;
`else
    localparam bit c_FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.BUF_DEPTH(BUF_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO of {addr,data}, pending bits, sticky error
    logic [36:0] mq[$];
    bit   [31:0] mpend;
    bit          merr;
    bit          e_ready;
    bit          e_drain;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_fwd(input logic [4:0] ra, output bit v, output logic [31:0] d);
        logic [36:0] e;
        v = 1'b0;
        d = 32'd0;
        if (c_FWD && ra != 5'd0) begin
            for (int k = mq.size() - 1; k >= 0; k--) begin
                e = mq[k];
                if (!v && e[36:32] == ra) begin
                    v = 1'b1;
                    d = e[31:0];
                end
            end
        end
    endtask

    task automatic eval();
        bit          f1v, f2v, grant, ehaz;
        logic [31:0] f1d, f2d;
        logic [36:0] head;
        @(negedge clk);
        e_ready = !rst && (mq.size() < BUF_DEPTH);
        grant   = !rst && bus.p_we && !bus.stallW && (bus.p_wa != 5'd0);
        e_drain = !rst && !grant && (mq.size() > 0);
        model_fwd(bus.ra1, f1v, f1d);
        model_fwd(bus.ra2, f2v, f2d);
        if (rst) begin
            f1v = 1'b0;
            f2v = 1'b0;
        end
        ehaz = !rst && ((mpend[bus.ra1] && !f1v) || (mpend[bus.ra2] && !f2v) || mpend[bus.dst]);
        check("m_ready", 32'(bus.m_ready), 32'(e_ready));
        check("we3", 32'(bus.we3), 32'(grant || e_drain));
        if (grant) begin
            check("wa3_pipe", 32'(bus.wa3), 32'(bus.p_wa));
            check("wd3_pipe", bus.wd3, bus.p_wd);
        end else if (e_drain) begin
            head = mq[0];
            check("wa3_drain", 32'(bus.wa3), 32'(head[36:32]));
            check("wd3_drain", bus.wd3, head[31:0]);
        end
        check("hazard", 32'(bus.hazard), 32'(ehaz));
        check("issue_err", 32'(bus.issue_err), 32'(merr));
        check("fwd1_v", 32'(bus.fwd1_v), 32'(f1v));
        check("fwd2_v", 32'(bus.fwd2_v), 32'(f2v));
        check("fwd1_d", bus.fwd1_d, f1d);
        check("fwd2_d", bus.fwd2_d, f2d);
    endtask

    task automatic adv();
        logic [36:0] head;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mpend = '0;
            merr  = 1'b0;
        end else begin
            if (bus.m_issue && bus.m_issue_wa != 5'd0 && mpend[bus.m_issue_wa]) merr = 1'b1;
            if (e_drain) begin
                head = mq.pop_front();
                mpend[head[36:32]] = 1'b0;
            end
            if (bus.m_valid && e_ready && bus.m_wa != 5'd0) mq.push_back({bus.m_wa, bus.m_wd});
            if (bus.m_issue && bus.m_issue_wa != 5'd0) mpend[bus.m_issue_wa] = 1'b1;
        end
        #1;
    endtask

    task automatic step();
        eval();
        adv();
    endtask

    task automatic idle();
        bus.stallW = 1'b0; bus.p_we = 1'b0; bus.p_wa = 5'd0; bus.p_wd = 32'd0;
        bus.m_issue = 1'b0; bus.m_issue_wa = 5'd0;
        bus.m_valid = 1'b0; bus.m_wa = 5'd0; bus.m_wd = 32'd0;
        bus.ra1 = 5'd0; bus.ra2 = 5'd0; bus.dst = 5'd0;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        // Reset with a pending pipeline write: outputs must stay quiet
        rst = 1'b1;
        bus.p_we = 1'b1; bus.p_wa = 5'd5; bus.p_wd = 32'h11;
        eval();
        check("rst_we3", 32'(bus.we3), 32'd0);
        check("rst_m_ready", 32'(bus.m_ready), 32'd0);
        check("rst_hazard", 32'(bus.hazard), 32'd0);
        adv();
        rst = 1'b0;

        // Direct pipeline write with empty buffer
        eval();
        check("pipe_we3", 32'(bus.we3), 32'd1);
        check("pipe_wa3", 32'(bus.wa3), 32'd5);
        check("pipe_wd3", bus.wd3, 32'h11);
        check("pipe_err", 32'(bus.issue_err), 32'd0);
        adv();
        idle();

        // Result for r8 blocked behind a busy pipeline
        bus.ra1 = 5'd8; bus.m_issue = 1'b1; bus.m_issue_wa = 5'd8;
        step();
        bus.m_issue = 1'b0;
        bus.m_valid = 1'b1; bus.m_wa = 5'd8; bus.m_wd = 32'hAB;
        bus.p_we = 1'b1; bus.p_wa = 5'd1; bus.p_wd = 32'h1234;
        eval();
        check("r8_accept", 32'(bus.m_ready), 32'd1);
        check("r8_haz0", 32'(bus.hazard), 32'd1);
        adv();
        bus.m_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            eval();
            check("r8_blocked", 32'(bus.wa3), 32'd1);
            check("r8_haz_hold", 32'(bus.hazard), c_FWD ? 32'd0 : 32'd1);
            adv();
        end
        bus.p_we = 1'b0;
        eval();
        check("r8_drain_wa", 32'(bus.wa3), 32'd8);
        check("r8_drain_wd", bus.wd3, 32'hAB);
        adv();
        eval();
        check("r8_haz_clr", 32'(bus.hazard), 32'd0);
        check("r8_idle_we", 32'(bus.we3), 32'd0);
        adv();
        idle();

        // Fill the two-entry buffer, hold off a third, check drain order
        bus.p_we = 1'b1; bus.p_wa = 5'd2; bus.p_wd = 32'h2;
        bus.m_valid = 1'b1; bus.m_wa = 5'd10; bus.m_wd = 32'h10;
        eval(); check("fill_rdy0", 32'(bus.m_ready), 32'd1); adv();
        bus.m_wa = 5'd11; bus.m_wd = 32'h20;
        eval(); check("fill_rdy1", 32'(bus.m_ready), 32'd1); adv();
        bus.m_wa = 5'd12; bus.m_wd = 32'h30;
        eval(); check("full_rdy", 32'(bus.m_ready), 32'd0); adv();
        bus.p_we = 1'b0;
        eval();
        check("full_rdy_drain", 32'(bus.m_ready), 32'd0);
        check("order_first", 32'(bus.wa3), 32'd10);
        adv();
        eval();
        check("third_accept", 32'(bus.m_ready), 32'd1);
        check("order_second", 32'(bus.wa3), 32'd11);
        check("order_second_d", bus.wd3, 32'h20);
        adv();
        bus.m_valid = 1'b0;
        eval(); check("order_third", 32'(bus.wa3), 32'd12); adv();
        step();
        idle();

        // Duplicate issue to r3
        reset_pulse();
        bus.dst = 5'd3; bus.m_issue = 1'b1; bus.m_issue_wa = 5'd3;
        step();
        eval(); check("dup_haz", 32'(bus.hazard), 32'd1); adv();
        bus.m_issue = 1'b0;
        eval();
        check("dup_err", 32'(bus.issue_err), 32'd1);
        check("dup_pending", 32'(bus.hazard), 32'd1);
        adv();
        bus.m_valid = 1'b1; bus.m_wa = 5'd3; bus.m_wd = 32'h33;
        step();
        bus.m_valid = 1'b0;
        eval();
        check("dup_drain", 32'(bus.wa3), 32'd3);
        check("dup_haz_drain", 32'(bus.hazard), 32'd1);
        adv();
        eval();
        check("dup_haz_clr", 32'(bus.hazard), 32'd0);
        check("dup_err_sticky", 32'(bus.issue_err), 32'd1);
        adv();
        idle();

        // Result to r0 is accepted and dropped
        reset_pulse();
        bus.m_valid = 1'b1; bus.m_wa = 5'd0; bus.m_wd = 32'hFFFF;
        eval();
        check("r0_accept", 32'(bus.m_ready), 32'd1);
        check("r0_we_a", 32'(bus.we3), 32'd0);
        adv();
        bus.m_valid = 1'b0;
        eval(); check("r0_we_b", 32'(bus.we3), 32'd0); adv();
        eval(); check("r0_we_c", 32'(bus.we3), 32'd0); adv();

        // Forwarding of buffered r9, then reset in the middle of draining
        bus.ra2 = 5'd9; bus.m_issue = 1'b1; bus.m_issue_wa = 5'd9;
        step();
        bus.m_issue = 1'b0;
        bus.p_we = 1'b1; bus.p_wa = 5'd4; bus.p_wd = 32'h4;
        bus.m_valid = 1'b1; bus.m_wa = 5'd9; bus.m_wd = 32'h55;
        step();
        bus.m_wa = 5'd7; bus.m_wd = 32'h77;
        eval();
        check("fwd2_v", 32'(bus.fwd2_v), 32'(c_FWD));
        check("fwd2_d", bus.fwd2_d, c_FWD ? 32'h55 : 32'd0);
        check("fwd_haz", 32'(bus.hazard), c_FWD ? 32'd0 : 32'd1);
        adv();
        bus.m_valid = 1'b0; bus.p_we = 1'b0;
        eval(); check("mid_drain", 32'(bus.wa3), 32'd9); adv();
        rst = 1'b1;
        eval();
        check("rst_mid_we3", 32'(bus.we3), 32'd0);
        check("rst_mid_rdy", 32'(bus.m_ready), 32'd0);
        check("rst_mid_fwd", 32'(bus.fwd2_v), 32'd0);
        adv();
        rst = 1'b0;
        eval();
        check("post_rst_we3", 32'(bus.we3), 32'd0);
        check("post_rst_rdy", 32'(bus.m_ready), 32'd1);
        adv();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 199) == 0);
            bus.stallW     = ($urandom_range(0, 4) == 0);
            bus.p_we       = ($urandom_range(0, 9) < 6);
            bus.p_wa       = 5'($urandom_range(0, 31));
            bus.p_wd       = $urandom;
            bus.m_issue    = ($urandom_range(0, 5) == 0);
            bus.m_issue_wa = 5'($urandom_range(0, 7));
            bus.m_valid    = ($urandom_range(0, 9) < 4);
            bus.m_wa       = 5'($urandom_range(0, 7));
            bus.m_wd       = $urandom;
            bus.ra1        = 5'($urandom_range(0, 7));
            bus.ra2        = 5'($urandom_range(0, 7));
            bus.dst        = 5'($urandom_range(0, 7));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
